// File: rtl/add_serial.sv
// Digit-serial adder/subtractor: latches operands, adds DIGIT bits per cycle
// through a RUN phase, then holds the result in DONE until it is consumed.
`timescale 1ns/1ps
module add_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NDIG = WIDTH / DIGIT;
   localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic [KW-1:0]    k_q, k_d;

   logic [DIGIT-1:0] dig_a, dig_b, dig_s;
   logic             dig_c;

   always_comb begin
      dig_a = '0;
      dig_b = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (k_q == KW'(i)) begin
            dig_a = a_q[i*DIGIT +: DIGIT];
            dig_b = b_q[i*DIGIT +: DIGIT];
         end
      end
   end

   assign {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT{1'b0}}, carry_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      k_d     = k_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction is A + ~B + ~borrow, so the adder path is shared.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? ~cin : cin;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NDIG; i++) begin
               if (k_q == KW'(i)) begin
                  sum_d[i*DIGIT +: DIGIT] = dig_s;
               end
            end
            carry_d = dig_c;
            if (k_q == K_LAST) begin
               cout_d  = dig_c;
               // a^b^s at the MSB recovers the carry into that bit.
               ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ dig_s[DIGIT-1] ^ dig_c;
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         k_q     <= k_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_add_serial.sv
// Scoreboard bench for add_serial: DIGIT=8 and DIGIT=32 instances, expected
// results queued at issue time and checked by monitors on each handshake.
`timescale 1ns/1ps
module tb_add_serial;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        iv0, ir0, cin0, sub0, ov0, or0, co0, of0;
   logic [31:0] a0, b0, s0;
   logic        iv1, ir1, cin1, sub1, ov1, or1, co1, of1;
   logic [31:0] a1, b1, s1;

   add_serial #(.WIDTH(32), .DIGIT(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0),
      .a(a0), .b(b0), .cin(cin0), .sub(sub0),
      .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .ovf(of0));

   add_serial #(.WIDTH(32), .DIGIT(32)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .cin(cin1), .sub(sub1),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1));

   typedef struct {
      logic [33:0] res;   // {ovf, cout, sum}
      int          acc;   // cycle index of the accepting edge
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   bp = 1'b0;
   logic pv0 = 1'b0;
   logic pv1 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got unexpected event/timeout, expected none", name);
   endtask

   // Reference: plain two's-complement arithmetic, overflow from operand/result signs.
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      logic [31:0] bb;
      logic        c;
      logic [32:0] full;
      logic        ov;
      bb   = sub ? ~b : b;
      c    = sub ? ~cin : cin;
      full = {1'b0, a} + {1'b0, bb} + {32'b0, c};
      ov   = (a[31] == bb[31]) && (full[31] != a[31]);
      return {ov, full};
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (ov0 && !pv0) begin
            if (q0.size() == 0) fail("unexpected_valid0");
            else chk("latency0", cyc - q0[0].acc, 4);
         end
         if (ov0 && or0) begin
            if (q0.size() == 0) fail("spurious_result0");
            else begin
               e0 = q0.pop_front();
               chk("result0", {of0, co0, s0}, e0.res);
            end
         end
      end
      pv0 <= ov0 & rst_n;
   end

   always @(negedge clk) begin
      #1;
      if (rst_n) begin
         if (ov1 && !pv1) begin
            if (q1.size() == 0) fail("unexpected_valid1");
            else chk("latency1", cyc - q1[0].acc, 1);
         end
         if (ov1 && or1) begin
            if (q1.size() == 0) fail("spurious_result1");
            else begin
               e1 = q1.pop_front();
               chk("result1", {of1, co1, s1}, e1.res);
            end
         end
      end
      pv1 <= ov1 & rst_n;
   end

   task automatic issue0(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic s, input logic [33:0] e);
      int n = 0;
      @(negedge clk);
      while (!ir0 && n < 200) begin
         if (bp) or0 = ($urandom % 3) != 0;
         @(negedge clk);
         n++;
      end
      if (!ir0) begin
         fail("accept_timeout0");
         return;
      end
      a0 = a; b0 = b; cin0 = c; sub0 = s; iv0 = 1'b1;
      q0.push_back('{res: e, acc: cyc + 1});
      @(negedge clk);
      iv0 = 1'b0;
      if (bp) or0 = ($urandom % 3) != 0;
   endtask

   task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic s, input logic [33:0] e);
      int n = 0;
      @(negedge clk);
      while (!ir1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ir1) begin
         fail("accept_timeout1");
         return;
      end
      a1 = a; b1 = b; cin1 = c; sub1 = s; iv1 = 1'b1;
      q1.push_back('{res: e, acc: cyc + 1});
      @(negedge clk);
      iv1 = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      logic [33:0] eh;
      int          n;
      int          prev;

      rst_n = 1'b0;
      iv0 = 0; a0 = 0; b0 = 0; cin0 = 0; sub0 = 0; or0 = 1;
      iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0; or1 = 1;
      #3;
      chk("reset_state0", {ov0, ir0, of0, co0, s0}, {1'b0, 1'b1, 34'b0});
      chk("reset_state1", {ov1, ir1, of1, co1, s1}, {1'b0, 1'b1, 34'b0});
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      chk("ready_after_release0", ir0, 1);

      issue0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
      issue0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
      issue0(32'h5, 32'h7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
      issue0(32'h7, 32'h5, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0001});

      bp = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ra = rand_op(); rb = rand_op(); rc = 1'($urandom); rs = 1'($urandom);
         issue0(ra, rb, rc, rs, model(ra, rb, rc, rs));
      end
      bp = 1'b0;
      or0 = 1'b1;

      // Result held in DONE while the upstream side keeps changing.
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      eh = model(ra, rb, rc, rs);
      issue0(ra, rb, rc, rs, eh);
      or0 = 1'b0;
      n = 0;
      while (!ov0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ov0) fail("hold_valid_timeout0");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         iv0 = ~iv0; a0 = $urandom; b0 = $urandom; cin0 = 1'($urandom); sub0 = 1'($urandom);
         chk("hold0", {ov0, ir0, of0, co0, s0}, {1'b1, 1'b0, eh});
      end
      iv0 = 1'b0;
      or0 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("idle_after_deliver0", {ov0, ir0}, 2'b01);

      // Abort mid-RUN with an asynchronous reset.
      ra = $urandom | 32'h0101_0101; rb = $urandom;
      issue0(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      q0.delete();
      #1;
      chk("async_reset0", {ov0, ir0, of0, co0, s0}, {1'b0, 1'b1, 34'b0});
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("no_valid_after_reset0", {ov0, ir0}, 2'b01);

      issue1(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {2'b00, 32'h2345_6789});

      // Back-to-back on the single-digit instance: one accept every NDIG+2 cycles.
      prev = 0;
      for (int k = 0; k < 8; k++) begin
         n = 0;
         @(negedge clk);
         while (!ir1 && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!ir1) begin
            fail("b2b_timeout1");
            break;
         end
         ra = rand_op(); rb = rand_op(); rc = 1'($urandom); rs = 1'($urandom);
         a1 = ra; b1 = rb; cin1 = rc; sub1 = rs; iv1 = 1'b1;
         q1.push_back('{res: model(ra, rb, rc, rs), acc: cyc + 1});
         if (k > 0) chk("b2b_interval1", cyc - prev, 3);
         prev = cyc;
      end
      @(negedge clk);
      iv1 = 1'b0;

      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) fail("drain");
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
